// File: rtl/rsa_pkg.sv
// Shared widths and load-sequencer state encoding for the RSA operand path.
package rsa_pkg;

    localparam int WORD_W  = 32;
    localparam int OP_W    = 1025;
    localparam int N_WORDS = 33;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FIRE   = 2'd2,
        WAIT   = 2'd3
    } ld_state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Word stream in, operand pair plus start/done handshake out to the adder.
interface operand_loader_if #(
    parameter int WORD_W = rsa_pkg::WORD_W,
    parameter int OP_W   = rsa_pkg::OP_W
);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_sub;
    logic              in_shift;
    logic [OP_W-1:0]   add_a;
    logic [OP_W-1:0]   add_b;
    logic              add_subtract;
    logic              add_shift;
    logic              add_start;
    logic              add_done;
    logic              busy;
    logic              op_done;

    // slave: the loader itself; master: upstream word source plus adder
    modport slave (
        input  in_valid, in_data, in_sub, in_shift, add_done,
        output in_ready, add_a, add_b, add_subtract, add_shift,
               add_start, busy, op_done
    );

    modport master (
        output in_valid, in_data, in_sub, in_shift, add_done,
        input  in_ready, add_a, add_b, add_subtract, add_shift,
               add_start, busy, op_done
    );

endinterface

// File: rtl/word_assembler.sv
// Indexed word write into a flat N_WORDS*WORD_W register, cleared by reset.
module word_assembler
    import rsa_pkg::*;
#(
    parameter  int WORD_W  = rsa_pkg::WORD_W,
    parameter  int N_WORDS = rsa_pkg::N_WORDS,
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [WORD_W-1:0]         wr_data,
    output logic [N_WORDS*WORD_W-1:0] words
);

    always_ff @(posedge clk) begin
        if (reset) begin
            words <= '0;
        end else if (wr_en) begin
            words[wr_idx*WORD_W +: WORD_W] <= wr_data;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Collects A then B word-serially, fires one start pulse at the adder and
// waits for its done pulse before accepting the next operand pair.
module operand_loader
    import rsa_pkg::*;
#(
    parameter int WORD_W  = rsa_pkg::WORD_W,
    parameter int OP_W    = rsa_pkg::OP_W,
    parameter int N_WORDS = rsa_pkg::N_WORDS
) (
    input  logic            clk,
    input  logic            reset,
    operand_loader_if.slave bus
);

    localparam int ASM_W = N_WORDS * WORD_W;
    localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    ld_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_q;
    logic             start_q;
    logic             busy_q;
    logic             op_done_q;
    logic             sub_q;
    logic             shift_q;
    logic             accept;
    logic             last_word;
    logic             wr_a;
    logic             wr_b;
    logic [ASM_W-1:0] asm_a;
    logic [ASM_W-1:0] asm_b;

    assign accept    = bus.in_valid & in_ready_q;
    assign last_word = (cnt == CNT_W'(N_WORDS - 1));
    assign wr_a      = accept && (state == LOAD_A);
    assign wr_b      = accept && (state == LOAD_B);

    word_assembler #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_WORDS)
    ) u_asm_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_a),
        .wr_idx  (cnt),
        .wr_data (bus.in_data),
        .words   (asm_a)
    );

    word_assembler #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_WORDS)
    ) u_asm_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_b),
        .wr_idx  (cnt),
        .wr_data (bus.in_data),
        .words   (asm_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD_A;
            cnt        <= '0;
            in_ready_q <= 1'b1;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            op_done_q  <= 1'b0;
            sub_q      <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            op_done_q <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        // Flags travel with A word 0 only.
                        if (cnt == '0) begin
                            sub_q   <= bus.in_sub;
                            shift_q <= bus.in_shift;
                        end
                        if (last_word) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (last_word) begin
                            cnt        <= '0;
                            state      <= FIRE;
                            in_ready_q <= 1'b0;
                            start_q    <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.add_done) begin
                        state      <= LOAD_A;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        op_done_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.add_a        = asm_a[OP_W-1:0];
    assign bus.add_b        = asm_b[OP_W-1:0];
    assign bus.add_subtract = sub_q;
    assign bus.add_shift    = shift_q;
    assign bus.add_start    = start_q;
    assign bus.busy         = busy_q;
    assign bus.op_done      = op_done_q;

    // Top-word bits above OP_W are stored but never forwarded.
    if (ASM_W > OP_W) begin : g_excess
        logic unused_excess;
        assign unused_excess = ^{asm_a[ASM_W-1:OP_W], asm_b[ASM_W-1:OP_W]};
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: loads, stalls, guard cases and resets.
module tb_operand_loader;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;

    always #5 clk = ~clk;

    operand_loader_if #(.WORD_W(32), .OP_W(1025)) bus ();

    operand_loader #(
        .WORD_W  (32),
        .OP_W    (1025),
        .N_WORDS (33)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Drive n words of v least-significant first; sub/shift are the intended
    // flags on A word 0, every other word carries the inverted flags.
    task automatic drive_words(input logic [1055:0] v, input int n, input bit is_a,
                               input bit sub, input bit shift, input bit stall);
        for (int k = 0; k < n; k++) begin
            if (stall) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 32'hDEADBEEF;
                bus.in_sub   = ~sub;
                bus.in_shift = ~shift;
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = v[k*32 +: 32];
            bus.in_sub   = (is_a && k == 0) ? sub : ~sub;
            bus.in_shift = (is_a && k == 0) ? shift : ~shift;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sub   = 1'b0;
        bus.in_shift = 1'b0;
    endtask

    task automatic pulse_done;
        bus.add_done = 1'b1;
        tick();
        bus.add_done = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.add_a !== '0 || bus.add_b !== '0) begin
            errors++; $display("FAIL reset_operands: got a=%h b=%h expected 0", bus.add_a, bus.add_b);
        end
        checks++;
        if ({bus.add_subtract, bus.add_shift, bus.add_start, bus.busy, bus.op_done} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000",
                {bus.add_subtract, bus.add_shift, bus.add_start, bus.busy, bus.op_done});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic;
        logic [1024:0] ea = 1025'd1;
        logic [1024:0] eb = 1025'd2;
        edges = 0;
        drive_words(1056'd1, 33, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_words(1056'd2, 33, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (edges !== 66 || bus.add_start !== 1'b1) begin
            errors++; $display("FAIL basic_start: got edges=%0d start=%b expected 66/1", edges, bus.add_start);
        end
        checks++;
        if (bus.add_a !== ea || bus.add_b !== eb) begin
            errors++; $display("FAIL basic_operands: got a=%h b=%h expected 1/2", bus.add_a, bus.add_b);
        end
        checks++;
        if (bus.add_subtract !== 1'b0 || bus.add_shift !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_fire_flags: got sub=%b sh=%b busy=%b rdy=%b expected 0/0/1/0",
                bus.add_subtract, bus.add_shift, bus.busy, bus.in_ready);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus.add_start !== 1'b0 || bus.busy !== 1'b1 || bus.op_done !== 1'b0) begin
            errors++; $display("FAIL basic_wait: got start=%b busy=%b done=%b expected 0/1/0",
                bus.add_start, bus.busy, bus.op_done);
        end
        pulse_done();
        checks++;
        if (bus.op_done !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_op_done: got done=%b busy=%b rdy=%b expected 1/0/1",
                bus.op_done, bus.busy, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.op_done !== 1'b0 || bus.add_a !== ea || bus.add_b !== eb) begin
            errors++; $display("FAIL basic_after_done: got done=%b a=%h expected 0/1", bus.op_done, bus.add_a);
        end
    endtask

    task automatic test_top_bit;
        logic [1055:0] va = '0;
        logic [1024:0] ea = '0;
        va[1024] = 1'b1;
        ea[1024] = 1'b1;
        drive_words(va, 33, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_words(1056'd1, 33, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.add_a !== ea || bus.add_a[1024] !== 1'b1 || bus.add_b !== 1025'd1) begin
            errors++; $display("FAIL top_bit_a: got a=%h b=%h expected bit1024 only/1", bus.add_a, bus.add_b);
        end
        checks++;
        if (bus.add_subtract !== 1'b1 || bus.add_shift !== 1'b0) begin
            errors++; $display("FAIL top_bit_sub: got sub=%b sh=%b expected 1/0", bus.add_subtract, bus.add_shift);
        end
        pulse_done();
        pulse_done();
        va[1055:1024] = 32'hFFFFFFFF;
        drive_words(va, 33, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_words(1056'd1, 33, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.add_a !== ea) begin
            errors++; $display("FAIL top_word_truncate: got a=%h expected bit1024 only", bus.add_a);
        end
        checks++;
        if (bus.add_subtract !== 1'b0 || bus.add_shift !== 1'b1) begin
            errors++; $display("FAIL top_shift_flag: got sub=%b sh=%b expected 0/1", bus.add_subtract, bus.add_shift);
        end
        pulse_done();
        pulse_done();
    endtask

    task automatic test_stall;
        edges = 0;
        drive_words(1056'd1, 33, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_words(1056'd2, 33, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (edges !== 132 || bus.add_start !== 1'b1) begin
            errors++; $display("FAIL stall_latency: got edges=%0d start=%b expected 132/1", edges, bus.add_start);
        end
        checks++;
        if (bus.add_a !== 1025'd1 || bus.add_b !== 1025'd2 || bus.add_subtract !== 1'b0) begin
            errors++; $display("FAIL stall_operands: got a=%h b=%h expected 1/2", bus.add_a, bus.add_b);
        end
        pulse_done();
        pulse_done();
    endtask

    task automatic test_wait_guard;
        logic [1055:0] vb = '0;
        logic [1024:0] eb = '0;
        vb[127:0]     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        vb[1055:1024] = 32'h0000_0003;
        eb[127:0]     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        eb[1024]      = 1'b1;
        drive_words(1056'd5, 33, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_words(vb, 33, 1'b0, 1'b1, 1'b1, 1'b0);
        pulse_done();
        checks++;
        if (bus.op_done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL done_in_fire: got done=%b busy=%b expected 0/1", bus.op_done, bus.busy);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        bus.in_sub   = 1'b0;
        bus.in_shift = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL wait_ready: got %b expected 0", bus.in_ready);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus.add_a !== 1025'd5 || bus.add_b !== eb || bus.add_subtract !== 1'b1 || bus.add_shift !== 1'b1) begin
            errors++; $display("FAIL wait_hold: got a=%h b=%h sub=%b sh=%b expected 5/pattern/1/1",
                bus.add_a, bus.add_b, bus.add_subtract, bus.add_shift);
        end
        bus.in_valid = 1'b0;
        pulse_done();
        checks++;
        if (bus.op_done !== 1'b1) begin
            errors++; $display("FAIL wait_op_done: got %b expected 1", bus.op_done);
        end
        drive_words(1056'd7, 33, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_done();
        tick();
        checks++;
        if (bus.op_done !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL done_in_load_b: got done=%b busy=%b rdy=%b expected 0/0/1",
                bus.op_done, bus.busy, bus.in_ready);
        end
        drive_words(1056'd9, 33, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.add_start !== 1'b1 || bus.add_a !== 1025'd7 || bus.add_b !== 1025'd9) begin
            errors++; $display("FAIL load_b_resume: got start=%b a=%h b=%h expected 1/7/9",
                bus.add_start, bus.add_a, bus.add_b);
        end
        pulse_done();
        pulse_done();
    endtask

    task automatic test_reset_midload;
        drive_words(1056'h1111_2222_3333_4444_5555_6666_7777_8888, 10, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hAAAA5555;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.add_a !== '0 || bus.add_b !== '0 || bus.add_subtract !== 1'b0 || bus.add_shift !== 1'b0) begin
            errors++; $display("FAIL midload_reset_ops: got a=%h sub=%b sh=%b expected 0", bus.add_a,
                bus.add_subtract, bus.add_shift);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.add_start !== 1'b0 || bus.op_done !== 1'b0) begin
            errors++; $display("FAIL midload_reset_ctl: got rdy=%b busy=%b start=%b done=%b expected 1/0/0/0",
                bus.in_ready, bus.busy, bus.add_start, bus.op_done);
        end
        drive_words(1056'd3, 33, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_words(1056'd4, 33, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.add_start !== 1'b1 || bus.add_a !== 1025'd3 || bus.add_b !== 1025'd4 || bus.add_shift !== 1'b1) begin
            errors++; $display("FAIL post_reset_load: got start=%b a=%h b=%h sh=%b expected 1/3/4/1",
                bus.add_start, bus.add_a, bus.add_b, bus.add_shift);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.add_a !== '0 || bus.add_shift !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL wait_reset: got busy=%b a=%h sh=%b rdy=%b expected 0/0/0/1",
                bus.busy, bus.add_a, bus.add_shift, bus.in_ready);
        end
        tick();
        tick();
        checks++;
        if (bus.add_start !== 1'b0 || bus.op_done !== 1'b0) begin
            errors++; $display("FAIL wait_reset_pending: got start=%b done=%b expected 0/0",
                bus.add_start, bus.op_done);
        end
        edges = 0;
        drive_words(1056'h0F0F, 33, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_words(1056'hF0F0, 33, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (edges !== 66 || bus.add_start !== 1'b1 || bus.add_a !== 1025'h0F0F || bus.add_b !== 1025'hF0F0) begin
            errors++; $display("FAIL fresh_load: got edges=%0d start=%b a=%h b=%h expected 66/1/0f0f/f0f0",
                edges, bus.add_start, bus.add_a, bus.add_b);
        end
        tick();
        pulse_done();
        checks++;
        if (bus.op_done !== 1'b1 || bus.add_subtract !== 1'b1) begin
            errors++; $display("FAIL fresh_op_done: got done=%b sub=%b expected 1/1", bus.op_done, bus.add_subtract);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sub   = 1'b0;
        bus.in_shift = 1'b0;
        bus.add_done = 1'b0;
        test_reset();
        test_basic();
        test_top_bit();
        test_stall();
        test_wait_guard();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
